tmds_decoder: RTL and testbench

//  Receive-side TMDS channel decoder, the inverse of the channel's TMDS encoder.

---
 rtl/tmds_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_tmds_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// ---------------------------------------------------------------------------
// tmds_decoder
//   Receive-side decoder for one TMDS channel, clocked at the pixel clock.
//   It searches for the 10-bit word boundary by bit-slipping until the four
//   control tokens line up repeatedly. Once locked, it decodes each aligned
//   word to either an 8-bit pixel byte or a 2-bit control code plus a blank
//   flag.
//
// Ports
//   clk       in   1   pixel clock
//   reset     in   1   asynchronous, active-high reset
//   raw       in   10  unaligned deserialized word, raw[0] received first
//   data      out  8   decoded pixel byte, 0 while blank
//   c         out  2   control code of the last control token, 00 when not blank
//   blank     out  1   1 during a control period or while not locked
//   locked    out  1   word alignment established
//   slip_pos  out  4   current bit offset into the two-word window, 0..9
// ---------------------------------------------------------------------------
module tmds_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       blank,
  output logic       locked,
  output logic [3:0] slip_pos
);

  localparam int TW = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int LW = $clog2(LOSS_TIMEOUT) + 1;
  localparam int CW = $clog2(LOCK_COUNT) + 1;

  localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Returns {is_token, control_code} for an aligned word.
  function automatic logic [2:0] token_lookup(input logic [9:0] word);
    logic [2:0] res;
    case (word)
      10'b1101010100: res = 3'b100;
      10'b0010101011: res = 3'b101;
      10'b0101010100: res = 3'b110;
      10'b1010101011: res = 3'b111;
      default:        res = 3'b000;
    endcase
    return res;
  endfunction

  // Undoes the optional inversion, then the xor/xnor transition chain.
  function automatic logic [7:0] decode_byte(input logic [9:0] word);
    logic [7:0] d;
    logic [7:0] q;
    d    = word[9] ? ~word[7:0] : word[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  // Offset advance modulo 10.
  function automatic logic [3:0] slip_inc(input logic [3:0] pos);
    logic [3:0] res;
    if (pos >= 4'd9) begin
      res = 4'd0;
    end else begin
      res = pos + 4'd1;
    end
    return res;
  endfunction

  state_t        state;
  state_t        state_next;
  logic [9:0]    prev;
  logic [18:0]   window;
  logic [9:0]    w;
  logic [2:0]    tok;
  logic [3:0]    slip_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [LW-1:0] loss;
  logic [LW-1:0] loss_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // raw[9] never lands in a 10-bit slice at offsets 0..9, so it is only
  // consumed through prev on the following cycle.
  assign window = {raw[8:0], prev};

  // Barrel select of the aligned word at the current slip offset.
  always_comb begin
    w = window[9:0];
    case (slip_pos)
      4'd0:    w = window[9:0];
      4'd1:    w = window[10:1];
      4'd2:    w = window[11:2];
      4'd3:    w = window[12:3];
      4'd4:    w = window[13:4];
      4'd5:    w = window[14:5];
      4'd6:    w = window[15:6];
      4'd7:    w = window[16:7];
      4'd8:    w = window[17:8];
      4'd9:    w = window[18:9];
      default: w = window[9:0];
    endcase
  end

  assign tok = token_lookup(w);

  // Alignment FSM: next state, slip offset, timers and token counter.
  always_comb begin
    state_next = state;
    slip_next  = slip_pos;
    timer_next = timer;
    loss_next  = loss;
    cnt_next   = cnt;
    case (state)
      SEARCH: begin
        // A token seen in the expiry cycle takes precedence over slipping.
        if (tok[2]) begin
          state_next = VERIFY;
          cnt_next   = CW'(1);
          timer_next = {TW{1'b0}};
        end else if (timer == SEARCH_LAST) begin
          slip_next  = slip_inc(slip_pos);
          timer_next = {TW{1'b0}};
        end else if (timer != {TW{1'b1}}) begin
          timer_next = timer + TW'(1);
        end else begin
          timer_next = timer;
        end
      end
      VERIFY: begin
        if (tok[2]) begin
          cnt_next = cnt + CW'(1);
          if (cnt >= LOCK_LAST) begin
            state_next = LOCKED;
            loss_next  = {LW{1'b0}};
          end else begin
            state_next = VERIFY;
          end
        end else begin
          state_next = SEARCH;
          slip_next  = slip_inc(slip_pos);
          timer_next = {TW{1'b0}};
          cnt_next   = {CW{1'b0}};
        end
      end
      LOCKED: begin
        if (tok[2]) begin
          loss_next = {LW{1'b0}};
        end else if (loss == LOSS_LAST) begin
          // Keep slip_pos so the previous offset is the first one re-tried.
          state_next = SEARCH;
          timer_next = {TW{1'b0}};
          cnt_next   = {CW{1'b0}};
          loss_next  = {LW{1'b0}};
        end else if (loss != {LW{1'b1}}) begin
          loss_next = loss + LW'(1);
        end else begin
          loss_next = loss;
        end
      end
      default: begin
        state_next = SEARCH;
        timer_next = {TW{1'b0}};
        cnt_next   = {CW{1'b0}};
        loss_next  = {LW{1'b0}};
      end
    endcase
  end

  // Alignment state registers and the previous-word history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      slip_pos <= 4'd0;
      timer    <= {TW{1'b0}};
      loss     <= {LW{1'b0}};
      cnt      <= {CW{1'b0}};
      prev     <= 10'd0;
    end else begin
      state    <= state_next;
      slip_pos <= slip_next;
      timer    <= timer_next;
      loss     <= loss_next;
      cnt      <= cnt_next;
      prev     <= raw;
    end
  end

  // Registered decode; gated by the state in the cycle the word was seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data   <= 8'd0;
      c      <= 2'b00;
      blank  <= 1'b1;
      locked <= 1'b0;
    end else begin
      locked <= (state_next == LOCKED);
      if (state != LOCKED) begin
        data  <= 8'd0;
        c     <= 2'b00;
        blank <= 1'b1;
      end else if (tok[2]) begin
        data  <= 8'd0;
        c     <= tok[1:0];
        blank <= 1'b1;
      end else begin
        data  <= decode_byte(w);
        c     <= 2'b00;
        blank <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_decoder
//   Self-checking bench for tmds_decoder. Stimulus is a serial bit stream of
//   encoded symbols, optionally preceded by junk bits to misalign it. Each
//   driven raw word pushes the expected decode of the symbol that starts in
//   it; the entry is popped once the decoder has produced that symbol.
// ---------------------------------------------------------------------------
module tb_tmds_decoder;

  logic       clk;
  logic       reset;
  logic [9:0] raw;
  logic [7:0] data;
  logic [1:0] c;
  logic       blank;
  logic       locked;
  logic [3:0] slip_pos;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       chk;
    logic [7:0] data;
    logic [1:0] c;
    logic       blank;
  } exp_t;

  exp_t sb[$];
  logic bitq[$];

  localparam logic [9:0] TOKS [4] = '{10'b1101010100, 10'b0010101011,
                                      10'b0101010100, 10'b1010101011};

  tmds_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .raw      (raw),
    .data     (data),
    .c        (c),
    .blank    (blank),
    .locked   (locked),
    .slip_pos (slip_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Forward TMDS encoder with a forced xor/xnor choice and inversion flag.
  function automatic logic [9:0] encode(input logic [7:0] b, input logic xr, input logic inv);
    logic [7:0] q;
    q[0] = b[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = xr ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
    end
    return {inv, xr, (inv ? ~q : q)};
  endfunction

  function automatic int tok_index(input logic [9:0] word);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) begin
      if (word == TOKS[i]) r = i;
    end
    return r;
  endfunction

  // Drive one raw word carrying the next symbol, then compare the previous one.
  task automatic send_word(input logic [9:0] word, input logic [7:0] byte_exp, input logic chk);
    exp_t e;
    int   ti;
    for (int i = 0; i < 10; i++) bitq.push_back(word[i]);
    for (int i = 0; i < 10; i++) raw[i] = bitq.pop_front();
    ti = tok_index(word);
    e.chk = chk;
    if (ti >= 0) begin
      e.data  = 8'd0;
      e.c     = 2'(ti);
      e.blank = 1'b1;
    end else begin
      e.data  = byte_exp;
      e.c     = 2'b00;
      e.blank = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      if (e.chk) begin
        check("sb_data", 32'(data), 32'(e.data));
        check("sb_c", 32'(c), 32'(e.c));
        check("sb_blank", 32'(blank), 32'(e.blank));
      end
    end
  endtask

  task automatic send_tok(input int idx);
    send_word(TOKS[idx], 8'd0, 1'b1);
  endtask

  // Reset, clear stream/scoreboard, and prepend 'offset' junk bits.
  task automatic do_reset(input int offset);
    reset = 1'b1;
    raw   = 10'd0;
    sb.delete();
    bitq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < offset; i++) bitq.push_back(1'b0);
  endtask

  initial begin
    reset = 1'b0;
    raw   = 10'd0;
    #2 reset = 1'b1;
    #1;
    check("rst_data", 32'(data), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_slip", 32'(slip_pos), 32'd0);

    // 1: aligned tokens then 0x5A (xor form)
    do_reset(0);
    for (int n = 1; n <= 20; n++) begin
      send_tok(0);
      check("t1_locked", 32'(locked), (n >= 9) ? 32'd1 : 32'd0);
    end
    check("t1_slip", 32'(slip_pos), 32'd0);
    send_word(encode(8'h5A, 1'b1, 1'b0), 8'h5A, 1'b1);

    // 3: the four tokens in sequence
    for (int i = 0; i < 4; i++) send_tok(i);
    send_tok(0);

    // 4: all bytes in all four encoded forms
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 256; b++) begin
        send_word(encode(8'(b), f[0], f[1]), 8'(b), 1'b1);
      end
    end
    send_tok(0);
    check("t4_locked", 32'(locked), 32'd1);

    // 2: stream misaligned by 3 bits
    do_reset(3);
    for (int n = 1; n <= 3090; n++) begin
      send_tok(0);
      if (n == 1023) check("t2_slip0", 32'(slip_pos), 32'd0);
      if (n == 1024) check("t2_slip1", 32'(slip_pos), 32'd1);
      if (n == 2047) check("t2_slip1b", 32'(slip_pos), 32'd1);
      if (n == 2048) check("t2_slip2", 32'(slip_pos), 32'd2);
      if (n == 3071) check("t2_slip2b", 32'(slip_pos), 32'd2);
      if (n == 3072) check("t2_slip3", 32'(slip_pos), 32'd3);
      if (n == 3079) check("t2_unlocked", 32'(locked), 32'd0);
      if (n == 3080) check("t2_locked", 32'(locked), 32'd1);
    end
    send_word(encode(8'h5A, 1'b1, 1'b0), 8'h5A, 1'b1);
    send_tok(0);
    check("t2_slip_final", 32'(slip_pos), 32'd3);

    // 5a: verify broken after five tokens
    do_reset(0);
    for (int n = 1; n <= 5; n++) send_tok(0);
    send_word(encode(8'h00, 1'b1, 1'b0), 8'h00, 1'b0);
    check("t5a_slip_before", 32'(slip_pos), 32'd0);
    send_word(encode(8'h00, 1'b1, 1'b0), 8'h00, 1'b0);
    check("t5a_slip_after", 32'(slip_pos), 32'd1);
    check("t5a_locked", 32'(locked), 32'd0);

    // 5b: loss of lock after LOSS_TIMEOUT data words
    do_reset(0);
    for (int n = 1; n <= 10; n++) send_tok(0);
    check("t5b_locked", 32'(locked), 32'd1);
    for (int n = 1; n <= 4096; n++) send_word(encode(8'h00, 1'b1, 1'b0), 8'h00, 1'b1);
    check("t5b_still_locked", 32'(locked), 32'd1);
    send_tok(0);
    check("t5b_lost", 32'(locked), 32'd0);
    check("t5b_slip", 32'(slip_pos), 32'd0);

    // 6: asynchronous reset between edges while locked
    do_reset(0);
    for (int n = 1; n <= 10; n++) send_tok(0);
    send_word(encode(8'h5A, 1'b0, 1'b1), 8'h5A, 1'b1);
    send_tok(1);
    check("t6_pre_locked", 32'(locked), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_data", 32'(data), 32'd0);
    check("t6_c", 32'(c), 32'd0);
    check("t6_blank", 32'(blank), 32'd1);
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_slip", 32'(slip_pos), 32'd0);
    #1 reset = 1'b0;
    sb.delete();
    bitq.delete();
    for (int n = 1; n <= 9; n++) begin
      send_tok(0);
      if (n == 8) check("t6_relock_pending", 32'(locked), 32'd0);
      if (n == 9) check("t6_relocked", 32'(locked), 32'd1);
    end
    send_word(encode(8'hC3, 1'b1, 1'b1), 8'hC3, 1'b1);
    send_tok(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
